// File: rtl/ram_dma_pkg.sv
// Shared types and helpers for the RAM DMA engines.
// Holds the word-offset helper, the read-engine state enum and the descriptor layout.
package ram_dma_pkg;

    // Number of byte-offset bits inside one data word.
    function automatic int lsb_of(input int axi_width);
        return $clog2(axi_width) - 3;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } mm2s_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] len;
    } mm2s_desc_t;

endpackage

// File: rtl/axis_skid2.sv
// Two-entry FIFO for the stream output; head entry is held stable until popped.
// The writer is trusted never to push while full.
module axis_skid2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_ready,
    output logic         rd_valid,
    output logic [W-1:0] rd_data,
    output logic [1:0]   occ
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic         rd_fire;

    assign rd_valid = (count != 2'd0);
    assign rd_fire  = rd_valid & rd_ready;
    assign rd_data  = rd_valid ? mem[rd_ptr] : '0;
    assign occ      = count;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (wr_en) begin
                wr_ptr <= ~wr_ptr;
            end
            if (rd_fire) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, wr_en} - {1'b0, rd_fire};
        end
    end

endmodule

// File: rtl/mm2s_ram_reader.sv
// Descriptor-driven RAM read engine producing an AXI-Stream with tkeep/tlast.
// Reads are throttled so that buffered plus in-flight words never exceed two.
module mm2s_ram_reader
    import ram_dma_pkg::*;
#(
    parameter int AXI_WIDTH      = 128,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int LEN_WIDTH      = 32
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           cmd_valid,
    output logic                                           cmd_ready,
    input  logic [AXI_ADDR_WIDTH-1:0]                      cmd_addr,
    input  logic [LEN_WIDTH-1:0]                           cmd_len,
    output logic                                           ren,
    output logic [AXI_ADDR_WIDTH-lsb_of(AXI_WIDTH)-1:0]    addr,
    input  logic [AXI_WIDTH-1:0]                           data,
    output logic                                           m_axis_tvalid,
    input  logic                                           m_axis_tready,
    output logic [AXI_WIDTH-1:0]                           m_axis_tdata,
    output logic [AXI_WIDTH/8-1:0]                         m_axis_tkeep,
    output logic                                           m_axis_tlast,
    output logic                                           busy,
    output logic                                           done
);

    localparam int LSB   = lsb_of(AXI_WIDTH);
    localparam int BYTES = AXI_WIDTH / 8;
    localparam int WA    = AXI_ADDR_WIDTH - LSB;
    localparam int CW    = LEN_WIDTH - LSB + 1;
    localparam int PW    = AXI_WIDTH + BYTES + 1;

    mm2s_state_e      state, state_nx;
    logic [WA-1:0]    addr_q;
    logic [CW-1:0]    issue_left;
    logic [BYTES-1:0] last_keep;
    logic             inflight, inflight_last, zero_done;
    logic             accept, pop, can_issue, drain_done;
    logic [1:0]       occ;
    logic             fifo_valid;
    logic [LEN_WIDTH:0] len_round;
    logic [CW-1:0]    nbeats;
    logic [LSB-1:0]   rem;
    logic [BYTES-1:0] rem_keep;
    logic [PW-1:0]    wr_payload, rd_payload;

    assign accept    = cmd_valid & cmd_ready;
    assign pop       = m_axis_tvalid & m_axis_tready;
    assign can_issue = ({1'b0, occ} + {2'b0, inflight}) < (3'd2 + {2'b0, pop});

    // Widened by one bit so a near-maximal length cannot overflow the round-up.
    assign len_round = {1'b0, cmd_len} + (LEN_WIDTH+1)'(BYTES - 1);
    assign nbeats    = CW'(len_round >> LSB);
    assign rem       = cmd_len[LSB-1:0];
    assign rem_keep  = (rem == '0) ? '1 : ~({BYTES{1'b1}} << rem);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:  if (accept && cmd_len != '0) state_nx = ST_RUN;
            ST_RUN:   if (ren && issue_left == CW'(1)) state_nx = ST_DRAIN;
            ST_DRAIN: if (drain_done) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready  = 1'b0;
        ren        = 1'b0;
        busy       = 1'b0;
        drain_done = 1'b0;
        if (!rst) begin
            unique case (state)
                ST_IDLE:  cmd_ready = ~zero_done;
                ST_RUN: begin
                    busy = 1'b1;
                    ren  = can_issue;
                end
                ST_DRAIN: begin
                    drain_done = (occ == 2'd0) && !inflight;
                    busy       = ~drain_done;
                end
                default: ;
            endcase
        end
    end

    assign done = drain_done | (zero_done & ~rst);
    assign addr = addr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q        <= '0;
            issue_left    <= '0;
            last_keep     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            zero_done     <= 1'b0;
        end else begin
            inflight      <= ren;
            inflight_last <= ren && (issue_left == CW'(1));
            zero_done     <= accept && (cmd_len == '0);
            if (accept) begin
                addr_q     <= WA'(cmd_addr >> LSB);
                issue_left <= nbeats;
                last_keep  <= rem_keep;
            end else if (ren) begin
                addr_q     <= addr_q + WA'(1);
                issue_left <= issue_left - CW'(1);
            end
        end
    end

    // The returning word is tagged with tlast/tkeep from the read that fetched it.
    assign wr_payload = {inflight_last, (inflight_last ? last_keep : {BYTES{1'b1}}), data};

    axis_skid2 #(.W(PW)) u_buf (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (inflight),
        .wr_data  (wr_payload),
        .rd_ready (m_axis_tready),
        .rd_valid (fifo_valid),
        .rd_data  (rd_payload),
        .occ      (occ)
    );

    assign m_axis_tvalid = fifo_valid & ~rst;
    assign m_axis_tdata  = rd_payload[AXI_WIDTH-1:0];
    assign m_axis_tkeep  = rst ? '0 : rd_payload[AXI_WIDTH +: BYTES];
    assign m_axis_tlast  = rd_payload[PW-1] & ~rst;

endmodule

// File: doc/mm2s_ram_reader.md
# mm2s_ram_reader

Memory-to-stream read engine: the initiator side of the accelerator's simple RAM read port (`ren`/`addr` out, `data` back one cycle later). It accepts a descriptor (byte base address and byte length), issues sequential word reads, and emits the words as an AXI-Stream with `tkeep`/`tlast`. Reads are throttled by downstream backpressure through a 2-entry buffer. One instance sits in front of each `mm2s_N` port in `top_ram`.

## Interface
- `AXI_WIDTH`, 128: data word width in bits; byte count `BYTES = AXI_WIDTH/8`.
- `AXI_ADDR_WIDTH`, 32: byte address width; word address width is `AXI_ADDR_WIDTH-LSB`, where `LSB = $clog2(AXI_WIDTH)-3`.
- `LEN_WIDTH`, 32: byte length width.

Ports:
- `clk`  in  1  clock. One clock; reset is synchronous and active-high.
- `rst`  in  1  synchronous active-high reset.
- `cmd_valid`  in  1  descriptor valid.
- `cmd_ready`  out  1  descriptor accepted when both high.
- `cmd_addr`  in  AXI_ADDR_WIDTH  byte base address; the low LSB bits are ignored and treated as zero.
- `cmd_len`  in  LEN_WIDTH  byte count; 0 is legal.
- `ren`  out  1  RAM read enable.
- `addr`  out  AXI_ADDR_WIDTH-LSB  RAM word address.
- `data`  in  AXI_WIDTH  RAM read data, valid the cycle after `ren`.
- `m_axis_tvalid`  out  1, `m_axis_tready`  in  1: stream handshake.
- `m_axis_tdata`  out  AXI_WIDTH, `m_axis_tkeep`  out  BYTES, `m_axis_tlast`  out  1: stream payload.
- `busy`  out  1  high from descriptor accept until done.
- `done`  out  1  one-cycle pulse when the transfer completes.

## Operation
- Beats: `nbeats = ceil(cmd_len/BYTES)`, latched at accept.
- `tkeep`:
  - All beats except the last carry all ones.
  - The last beat carries the low `r` bits set, where `r = cmd_len mod BYTES`; if `r == 0`, all ones.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE: `cmd_ready = 1`. On accept, if `cmd_len == 0`, pulse `done` next cycle and stay in IDLE. Otherwise load the word address and beat counter and go to RUN.
  - RUN: issue `ren` at the current address, then increment the address and decrement the remaining count. When the last read has been issued, go to DRAIN.
  - DRAIN: wait until the buffer is empty, nothing is in flight, and the final beat has handshaken. Then pulse `done` and go to IDLE.
- Issue rule: `ren` is allowed when `occ + inflight - pop < 2`.
  - `occ` is buffer occupancy; `inflight` is 1 if `ren` was asserted last cycle.
  - `pop = m_axis_tvalid & m_axis_tready`.
- `data` is written into the buffer unconditionally in the cycle after `ren`. The issue rule guarantees the buffer never overflows.
- The word address is a free-running counter and wraps modulo `2^(AXI_ADDR_WIDTH-LSB)`.
- `cmd_ready` is 0 outside IDLE. A new descriptor is never accepted in the same cycle as `done`.

## Timing
- Reset values: `ren = 0`, `addr = 0`, `m_axis_tvalid = 0`, `tlast = 0`, `tkeep = 0`, `busy = 0`, `done = 0`, `cmd_ready = 0` while `rst` is high. The FSM resets to IDLE.
- Latency: accept at cycle T → first `ren` at T+1 → first `tvalid` at T+3 (data registered at T+2, buffer output at T+3).
- Throughput: 1 beat/cycle with `tready` held high.
- Stream payload is stable while `tvalid & !tready`. `tvalid` never drops without a handshake.
- `done` asserts in the cycle after the final `tlast` handshake. `busy` falls in the same cycle.
- Reset mid-transfer clears all state; a pending in-flight read response is discarded. `cmd_ready` goes high the cycle after `rst` deasserts.

## Structure
- Package `ram_dma_pkg`: `LSB` function of `AXI_WIDTH`, state enum `mm2s_state_e`, and a descriptor struct (addr, len).
- Sub-module `axis_skid2`: a 2-entry FIFO (data + keep + last) with occupancy output, used for the output buffer.
- The top level holds the FSM, address/beat counters, in-flight flag, and tkeep/tlast generation.

## Test plan
- Aligned transfer: `cmd_addr = 0x100`, `cmd_len = 64`, `tready = 1` → `ren` on 4 consecutive cycles with `addr` 0x10..0x13; 4 beats with `tkeep = 0xFFFF`; `tlast` on beat 4; `done` 1 cycle later.
- Partial last beat: `cmd_len = 20` → 2 beats; beat 2 has `tkeep = 0x000F` and `tlast = 1`.
- Backpressure: 16-beat transfer with `tready` low every other cycle → data equals memory contents in order, no loss or duplication, and `occ + inflight ≤ 2` at all times.
- Zero length: `cmd_len = 0` → no `ren`, no `tvalid`; `done` pulses the cycle after accept.
- Reset mid-transfer: assert `rst` after beat 2 of 8 → next cycle `ren = 0` and `tvalid = 0`; the next 32-byte command completes correctly with exactly 2 beats.
- Address wrap: `cmd_addr = 0xFFFFFFF0`, `cmd_len = 32` → `addr` sequence 0x0FFFFFFF, 0x0000000; 2 beats.
